// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared divide op encoding, writeback select encoding and op decode helpers.
package div_unit_pkg;
  typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_t;
  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_MUL, WB_DIV} wb_sel_t;
  function automatic logic op_signed(div_op_t op);
    return op == DIV || op == REM;
  endfunction
  function automatic logic op_rem(div_op_t op);
    return op == REM || op == REMU;
  endfunction
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage divider request/stall/result bundle; master = pipeline, slave = divider.
interface div_unit_if #(parameter int XLEN = 32);
  import div_unit_pkg::*;
  logic            div_req;
  div_op_t         div_op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            pipe_enable;
  logic            flush;
  logic            div_wait;
  logic [XLEN-1:0] result;
  modport master (output div_req, div_op, dividend, divisor, pipe_enable, flush, input div_wait, result);
  modport slave (input div_req, div_op, dividend, divisor, pipe_enable, flush, output div_wait, result);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] q_o
);
  logic [XLEN:0] sh, diff;
  assign sh    = {rem_i, q_i[XLEN-1]};
  assign diff  = sh - {1'b0, dvs_i};
  assign rem_o = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
  assign q_o   = {q_i[XLEN-2:0], ~diff[XLEN]};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU/REM/REMU with div_wait stall output.
// DIV_RADIX4_EN chains two div_step stages so each BUSY cycle retires two quotient bits.
module div_unit import div_unit_pkg::*; #(parameter int XLEN = 32) (
  input logic       clk,
  input logic       reset_n,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state_q, state_d;
  div_op_t         op_q, op_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d, q_q, q_d, dvs_q, dvs_d, result_q, result_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0] rem_1, q_1, rem_s, q_s, a_abs, b_abs;
  logic            a_neg, b_neg;
  div_step #(.XLEN(XLEN)) u_step0 (.rem_i(rem_q), .q_i(q_q), .dvs_i(dvs_q), .rem_o(rem_1), .q_o(q_1));
`ifdef DIV_RADIX4_EN
  localparam logic [CW-1:0] LAST = CW'(XLEN/2-1);
  div_step #(.XLEN(XLEN)) u_step1 (.rem_i(rem_1), .q_i(q_1), .dvs_i(dvs_q), .rem_o(rem_s), .q_o(q_s));
`else
  localparam logic [CW-1:0] LAST = CW'(XLEN-1);
  assign rem_s = rem_1;
  assign q_s   = q_1;
`endif
  assign a_neg = op_signed(bus.div_op) & bus.dividend[XLEN-1];
  assign b_neg = op_signed(bus.div_op) & bus.divisor[XLEN-1];
  assign a_abs = a_neg ? -bus.dividend : bus.dividend;
  assign b_abs = b_neg ? -bus.divisor : bus.divisor;
  assign bus.div_wait = reset_n & ~bus.flush & ((state_q == IDLE & bus.div_req) | state_q == BUSY);
  assign bus.result   = result_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    rem_d    = rem_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (bus.flush)
      state_d = IDLE;
    else if (state_q == IDLE && bus.div_req) begin
      op_d    = bus.div_op;
      qneg_d  = a_neg ^ b_neg;
      rneg_d  = a_neg;
      q_d     = a_abs;
      dvs_d   = b_abs;
      rem_d   = '0;
      count_d = '0;
      state_d = BUSY;
      // Divide-by-zero and signed overflow bypass the iteration entirely
      if (bus.divisor == '0) begin
        result_d = op_rem(bus.div_op) ? bus.dividend : '1;
        state_d  = DONE;
      end else if (op_signed(bus.div_op) && bus.dividend == {1'b1, {(XLEN-1){1'b0}}} && bus.divisor == '1) begin
        result_d = op_rem(bus.div_op) ? '0 : bus.dividend;
        state_d  = DONE;
      end
    end else if (state_q == BUSY) begin
      rem_d   = rem_s;
      q_d     = q_s;
      count_d = count_q + CW'(1);
      if (count_q == LAST) begin
        result_d = op_rem(op_q) ? (rneg_q ? -rem_s : rem_s) : (qneg_q ? -q_s : q_s);
        state_d  = DONE;
      end
    end else if (state_q == DONE && bus.pipe_enable)
      state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= DIV;
      count_q  <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (either radix build).
module tb_div_unit;
  import div_unit_pkg::*;
  localparam int XLEN = 32;
`ifdef DIV_RADIX4_EN
  localparam int NW = XLEN/2 + 1;
`else
  localparam int NW = XLEN + 1;
`endif
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wait_prev = 1'b0;
  logic [31:0] last_res = '0;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  div_unit_if #(.XLEN(XLEN)) bus();
  div_unit #(.XLEN(XLEN)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  // div_req must stay high for the cycle after any stalled cycle
  always @(posedge clk) begin
    assert (!(wait_prev && !bus.div_req)) else $error("div_req dropped while div_wait was high");
    wait_prev <= bus.div_wait;
  end
  task automatic run(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int ew, input string nm);
    int n = 0;
    @(posedge clk); #1;
    bus.div_req = 1'b1; bus.div_op = op; bus.dividend = a; bus.divisor = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.div_wait) break;
      n++;
      @(posedge clk);
    end
    checks++;
    if (n !== ew) begin errors++; $display("FAIL %s wait: got %0d cycles, expected %0d", nm, n, ew); end
    checks++;
    if (bus.result !== exp) begin errors++; $display("FAIL %s result: got %h, expected %h", nm, bus.result, exp); end
    last_res = exp;
    @(posedge clk); #1;
    bus.div_req = 1'b0;
  endtask
  task automatic test_reset();
    bus.div_req = 1'b1; bus.div_op = DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7;
    bus.pipe_enable = 1'b1; bus.flush = 1'b0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.div_wait !== 1'b0) begin errors++; $display("FAIL reset wait: got %b, expected 0", bus.div_wait); end
    checks++;
    if (bus.result !== 32'h0) begin errors++; $display("FAIL reset result: got %h, expected 0", bus.result); end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.div_req = 1'b0;
  endtask
  task automatic test_unsigned();
    run(DIVU, 32'd100, 32'd7, 32'd14, NW, "divu_100_7");
    run(REMU, 32'd100, 32'd7, 32'd2, NW, "remu_100_7");
  endtask
  task automatic test_signed();
    run(DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, NW, "div_m7_2");
    run(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, NW, "rem_m7_2");
    run(DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, NW, "div_100_m7");
    run(REM, 32'd100, 32'hFFFFFFF9, 32'd2, NW, "rem_100_m7");
  endtask
  task automatic test_div_zero();
    run(DIVU, 32'h1234, 32'h0, 32'hFFFFFFFF, 1, "divu_by0");
    run(REMU, 32'h1234, 32'h0, 32'h1234, 1, "remu_by0");
    run(REM, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 1, "rem_m7_by0");
  endtask
  task automatic test_overflow();
    run(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run(REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "rem_ovf");
    run(DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0, NW, "divu_no_ovf");
  endtask
  task automatic test_stall_done();
    int n = 0;
    @(posedge clk); #1;
    bus.pipe_enable = 1'b0;
    bus.div_req = 1'b1; bus.div_op = DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.div_wait) break;
      n++;
      @(posedge clk);
    end
    checks++;
    if (n !== NW) begin errors++; $display("FAIL stall_done wait: got %0d cycles, expected %0d", n, NW); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.div_wait !== 1'b0) begin errors++; $display("FAIL stall_done hold%0d wait: got %b, expected 0", k, bus.div_wait); end
      checks++;
      if (bus.result !== 32'd14) begin errors++; $display("FAIL stall_done hold%0d result: got %h, expected %h", k, bus.result, 32'd14); end
      @(posedge clk); @(negedge clk);
    end
    @(posedge clk); #1;
    bus.pipe_enable = 1'b1;
    @(posedge clk); #1;
    bus.div_req = 1'b0;
    last_res = 32'd14;
    run(DIVU, 32'h1234, 32'h0, 32'hFFFFFFFF, 1, "after_stall_idle");
  endtask
  task automatic test_flush();
    @(posedge clk); #1;
    bus.div_req = 1'b1; bus.div_op = DIVU; bus.dividend = 32'd1000; bus.divisor = 32'd10;
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.div_wait !== 1'b1) begin errors++; $display("FAIL flush busy9 wait: got %b, expected 1", bus.div_wait); end
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.div_wait !== 1'b0) begin errors++; $display("FAIL flush cycle wait: got %b, expected 0", bus.div_wait); end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.div_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_wait !== 1'b0) begin errors++; $display("FAIL flush next wait: got %b, expected 0", bus.div_wait); end
    checks++;
    if (bus.result !== last_res) begin errors++; $display("FAIL flush result: got %h, expected %h", bus.result, last_res); end
    repeat (NW + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.result !== last_res) begin errors++; $display("FAIL flush later result: got %h, expected %h", bus.result, last_res); end
    run(DIVU, 32'd9, 32'd3, 32'd3, NW, "divu_9_3_after_flush");
  endtask
  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.div_req = 1'b1; bus.div_op = DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.div_wait !== 1'b0) begin errors++; $display("FAIL reset_mid wait: got %b, expected 0", bus.div_wait); end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.div_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_mid result: got %h, expected 0", bus.result); end
    run(REMU, 32'hFFFFFFFF, 32'd10, 32'd5, NW, "remu_after_reset");
  endtask
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_stall_done();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
